// File: rtl/lsu_ram_bridge.sv
// Load/store bridge: turns one core request at a time into an aligned 64-bit
// RAM access, lane-shifting store data and extracting/extending load data.
module lsu_ram_bridge #(
    parameter logic [63:0] BASE = 64'h8000_0000,
    parameter logic [63:0] SPAN = 64'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [63:0] ram_raddr,
    input  logic [63:0] ram_rdata,
    output logic [63:0] ram_waddr,
    output logic [63:0] ram_wdata,
    output logic [7:0]  ram_wstrb,
    output logic        ram_wen
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    typedef struct packed {
        logic [2:0] off;
        logic [1:0] size;
        logic       uns;
        logic       wen;
    } req_t;

    state_t      state_q, state_d;
    req_t        rq;
    logic        accept, misal, legal;
    logic [7:0]  strb;
    logic [63:0] aligned, shifted, extracted;

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign aligned   = {req_addr[63:3], 3'b000};
    // Subtract before compare so BASE+SPAN never has to be formed.
    assign legal     = (req_addr >= BASE) && ((req_addr - BASE) < SPAN);

    always_comb begin
        misal = 1'b0;
        strb  = 8'h00;
        case (req_size)
            2'd0: begin misal = 1'b0;              strb = 8'h01; end
            2'd1: begin misal = req_addr[0];       strb = 8'h03; end
            2'd2: begin misal = |req_addr[1:0];    strb = 8'h0F; end
            default: begin misal = |req_addr[2:0]; strb = 8'hFF; end
        endcase
    end

    always_comb begin
        shifted   = ram_rdata >> {rq.off, 3'b000};
        extracted = shifted;
        case (rq.size)
            2'd0: extracted = rq.uns ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: extracted = rq.uns ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: extracted = rq.uns ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: extracted = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (misal || !legal) ? RESP : ACCESS;
            ACCESS:  state_d = rq.wen ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rq         <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= '0;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_wstrb  <= '0;
            ram_wen    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    rq <= '{off: req_addr[2:0], size: req_size, uns: req_unsigned, wen: req_wen};
                    if (misal || !legal) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= misal ? 2'd1 : 2'd2;
                    end else begin
                        // RAM-side outputs are set here so they are visible during ACCESS.
                        ram_raddr <= aligned;
                        ram_waddr <= aligned;
                        ram_wen   <= req_wen;
                        ram_wstrb <= req_wen ? 8'(strb << req_addr[2:0]) : 8'h00;
                        if (req_wen) ram_wdata <= req_wdata << {req_addr[2:0], 3'b000};
                    end
                end
                ACCESS: begin
                    ram_wen   <= 1'b0;
                    ram_wstrb <= 8'h00;
                    if (rq.wen) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'd0;
                    end
                end
                CAPTURE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= extracted;
                    resp_err   <= 2'd0;
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Directed bench for lsu_ram_bridge with a small word-addressed RAM model.
module tb_lsu_ram_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [63:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
    logic [7:0]  ram_wstrb;
    logic        ram_wen;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;

    logic [63:0] mem [0:15];

    lsu_ram_bridge dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_wen(ram_wen)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wen)
            for (int b = 0; b < 8; b++)
                if (ram_wstrb[b]) mem[ram_waddr[6:3]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_raddr[6:3]];
    end

    always @(negedge clock) if (ram_wen) wen_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic w, input logic [1:0] sz,
                        input logic u, input logic [63:0] wd);
        @(negedge clock);
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz;
        req_unsigned = u; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic done();
        @(posedge clock); #1;
    endtask

    task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] exp_d, input logic [1:0] exp_e,
                           input int exp_lat);
        int lat;
        send(a, 1'b0, sz, u, 64'h0);
        wait_resp(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, resp_rdata, exp_d);
        chk({tag, "_err"}, {62'b0, resp_err}, {62'b0, exp_e});
        done();
    endtask

    initial begin
        int lat;
        int w0;
        logic ok;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ram", {ram_wen, ram_wstrb}, 64'h0);
        chk("rst_raddr", ram_raddr | ram_waddr | ram_wdata, 64'h0);
        chk("rst_resp", {resp_valid, resp_err, req_ready}, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        @(negedge clock) reset = 1'b1;

        // Store word into the upper half of word 0.
        w0 = wen_cnt;
        send(64'h8000_0004, 1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF);
        chk("st_waddr", ram_waddr, 64'h8000_0000);
        chk("st_wstrb", {56'b0, ram_wstrb}, 64'hF0);
        chk("st_wdata", ram_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("st_wen", {63'b0, ram_wen}, 64'd1);
        wait_resp(lat);
        chk("st_lat", 64'(lat), 64'd2);
        chk("st_err", {62'b0, resp_err}, 64'd0);
        chk("st_rdata", resp_rdata, 64'h0);
        chk("st_wen_pulse", 64'(wen_cnt - w0), 64'd1);
        done();

        send(64'h8000_0000, 1'b1, 2'd3, 1'b0, 64'h8011_2233_4455_6677);
        wait_resp(lat);
        done();
        do_load("lb_s", 64'h8000_0007, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 3);
        do_load("lb_u", 64'h8000_0007, 2'd0, 1'b1, 64'h80, 2'd0, 3);
        do_load("lh_s", 64'h8000_0002, 2'd1, 1'b0, 64'h4455, 2'd0, 3);

        w0 = wen_cnt;
        do_load("mis", 64'h8000_0001, 2'd1, 1'b0, 64'h0, 2'd1, 1);
        chk("mis_raddr", ram_raddr, 64'h8000_0000);
        chk("mis_wen", 64'(wen_cnt - w0), 64'd0);
        do_load("oor", 64'h7FFF_FFF8, 2'd3, 1'b0, 64'h0, 2'd2, 1);
        do_load("oor_hi", 64'h8800_0000, 2'd0, 1'b0, 64'h0, 2'd2, 1);

        // Stalled response must hold steady and block new requests.
        resp_ready = 1'b0;
        send(64'h8000_0000, 1'b0, 2'd0, 1'b0, 64'h0);
        wait_resp(lat);
        chk("stall_lat", 64'(lat), 64'd3);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            if (!resp_valid || resp_rdata !== 64'h77 || resp_err !== 2'd0 || req_ready) ok = 1'b0;
        end
        chk("stall_stable", {63'b0, ok}, 64'd1);
        @(negedge clock) resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("stall_release", {62'b0, resp_valid, req_ready}, 64'b01);
        do_load("post_stall", 64'h8000_0006, 2'd0, 1'b1, 64'h11, 2'd0, 3);

        send(64'h8000_0003, 1'b1, 2'd0, 1'b0, 64'h1234_56AB);
        chk("sb_wstrb", {56'b0, ram_wstrb}, 64'h08);
        chk("sb_wdata", ram_wdata[31:0], 64'hAB00_0000);
        wait_resp(lat);
        done();
        do_load("lb_after_sb", 64'h8000_0003, 2'd0, 1'b1, 64'hAB, 2'd0, 3);

        // Reset during the ACCESS cycle of a store.
        send(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mid_pre", {63'b0, ram_wen}, 64'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid_wen", {63'b0, ram_wen}, 64'd0);
        chk("rst_mid_resp", {62'b0, resp_valid, req_ready}, 64'd0);
        @(negedge clock) reset = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            if (resp_valid || ram_wen) ok = 1'b0;
        end
        chk("rst_no_resp", {63'b0, ok}, 64'd1);
        do_load("post_rst", 64'h8000_0004, 2'd2, 1'b0, 64'hFFFF_FFFF_8011_2233, 2'd0, 3);

        send(64'h8000_0008, 1'b1, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
        chk("sd_wstrb", {56'b0, ram_wstrb}, 64'hFF);
        chk("sd_waddr", ram_waddr, 64'h8000_0008);
        wait_resp(lat);
        chk("sd_lat", 64'(lat), 64'd2);
        done();
        do_load("lw_after_sd", 64'h8000_000C, 2'd2, 1'b0, 64'h0123_4567, 2'd0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
